// File: rtl/key_expansion_if.sv
// Handshake and round-key bus between a key-expansion requester and the
// AES-128 key expansion engine.
interface key_expansion_if;
    logic         start;
    logic [127:0] cipher_key;
    logic         ready;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic [3:0]   round_idx;
    logic         done;

    modport master (
        output start, cipher_key,
        input  ready, round_key, round_key_valid, round_idx, done
    );

    modport slave (
        input  start, cipher_key,
        output ready, round_key, round_key_valid, round_idx, done
    );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key expansion: produces round keys 0..10 on consecutive cycles after
// an accepted start, one round key per clock.

// Byte substitution: multiplicative inverse in GF(2^8) followed by the affine map.
module sBox (
    input  logic [7:0] value,
    output logic [7:0] substituted
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Inverse as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero naturally.
    always_comb begin
        sq  = value;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        substituted = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_expansion (
    input  logic           clk,
    input  logic           rst_n,
    key_expansion_if.slave bus
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state;
    state_t       next_state;
    logic [127:0] key_q;
    logic [3:0]   idx_q;
    logic [7:0]   rcon_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  n0, n1, n2, n3;
    logic         accept;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w3           = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        sBox u_sbox (
            .value       (rot_w3[8*b +: 8]),
            .substituted (sub_w3[8*b +: 8])
        );
    end

    assign n0 = w0 ^ sub_w3 ^ {rcon_q, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign accept     = (state == IDLE) && bus.start;
    assign last_round = (state == EXPAND) && (idx_q == 4'd10);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The FSM stays in EXPAND through the round-10 cycle, leaving exactly one
    // idle cycle before a held start can be accepted again.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (bus.start) next_state = EXPAND;
            EXPAND: if (last_round) next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q  <= 128'h0;
            idx_q  <= 4'h0;
            rcon_q <= 8'h01;
        end else if (accept) begin
            key_q  <= bus.cipher_key;
            idx_q  <= 4'h0;
            rcon_q <= 8'h01;
        end else if (state == EXPAND && !last_round) begin
            key_q  <= {n0, n1, n2, n3};
            idx_q  <= idx_q + 4'd1;
            rcon_q <= xtime(rcon_q);
        end
    end

    always_comb begin
        bus.ready           = (state == IDLE);
        bus.round_key_valid = (state == EXPAND);
        bus.done            = last_round;
        bus.round_key       = key_q;
        bus.round_idx       = idx_q;
    end
endmodule
